// File: rtl/instr_mem_fetch.sv
// Word-organised instruction memory with a valid/ready fetch port, one-entry response
// register, program-load port and post-reset clear engine. Optional parity: INSTR_MEM_PARITY_EN.
module instr_mem_fetch #(
    parameter int              XLEN       = 32,
    parameter int              DEPTH      = 64,
    parameter int              ADDR_W     = 32,
    parameter logic [XLEN-1:0] RESET_WORD = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst,
    output logic              busy,
    input  logic              f_valid,
    output logic              f_ready,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              r_valid,
    input  logic              r_ready,
    output logic [XLEN-1:0]   r_instr,
    output logic              r_misalign,
    output logic              r_oob,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [XLEN-1:0]   ld_data,
`ifdef INSTR_MEM_PARITY_EN
    output logic              r_perr,
    input  logic              ld_flip_par,
`endif
    output logic              ld_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {CLEAR, READY} state_t;

    state_t           state;
    logic [IDX_W-1:0] clr_idx;
    logic [XLEN-1:0]  mem [DEPTH];
`ifdef INSTR_MEM_PARITY_EN
    logic             par_mem [DEPTH];
    logic             wr_par;
`endif

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] ld_idx;
    logic             f_mis;
    logic             f_oob;
    logic             f_ok;
    logic             ld_ok;
    logic             f_fire;
    logic             ld_fire;
    logic             wr_en;
    logic [IDX_W-1:0] wr_idx;
    logic [XLEN-1:0]  wr_data;

    // DEPTH is a power of two, so any set bit above the index field means out of bounds
    assign f_idx  = f_addr[IDX_W+1:2];
    assign f_mis  = f_addr[1:0] != 2'b00;
    assign f_oob  = |f_addr[ADDR_W-1:IDX_W+2];
    assign f_ok   = !f_mis && !f_oob;
    assign ld_idx = ld_addr[IDX_W+1:2];
    assign ld_ok  = (ld_addr[1:0] == 2'b00) && !(|ld_addr[ADDR_W-1:IDX_W+2]);

    assign busy     = state == CLEAR;
    assign ld_ready = state == READY;
    assign f_ready  = (state == READY) && (!r_valid || r_ready);
    assign f_fire   = f_valid && f_ready;
    assign ld_fire  = ld_valid && ld_ready;

    always_comb begin
        wr_en   = 1'b0;
        wr_idx  = clr_idx;
        wr_data = RESET_WORD;
`ifdef INSTR_MEM_PARITY_EN
        wr_par  = ^RESET_WORD;
`endif
        if (!rst) begin
            if (state == CLEAR) begin
                wr_en = 1'b1;
            end else if (ld_fire && ld_ok) begin
                wr_en   = 1'b1;
                wr_idx  = ld_idx;
                wr_data = ld_data;
`ifdef INSTR_MEM_PARITY_EN
                wr_par  = (^ld_data) ^ ld_flip_par;
`endif
            end
        end
    end

    // Storage is not reset; the clear engine initialises it instead
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_data;
`ifdef INSTR_MEM_PARITY_EN
            par_mem[wr_idx] <= wr_par;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CLEAR;
            clr_idx    <= '0;
            r_valid    <= 1'b0;
            r_instr    <= '0;
            r_misalign <= 1'b0;
            r_oob      <= 1'b0;
            ld_err     <= 1'b0;
`ifdef INSTR_MEM_PARITY_EN
            r_perr     <= 1'b0;
`endif
        end else begin
            ld_err <= ld_fire && !ld_ok;
            if (state == CLEAR) begin
                clr_idx <= clr_idx + 1'b1;
                if (clr_idx == IDX_W'(DEPTH - 1))
                    state <= READY;
            end
            // Reading here returns the pre-write contents on a same-edge load collision
            if (f_fire) begin
                r_valid    <= 1'b1;
                r_misalign <= f_mis;
                r_oob      <= f_oob;
                r_instr    <= f_ok ? mem[f_idx] : '0;
`ifdef INSTR_MEM_PARITY_EN
                r_perr     <= f_ok && (par_mem[f_idx] != ^mem[f_idx]);
`endif
            end else if (r_valid && r_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

endmodule
